// File: rtl/hack_kbd.sv
// PS/2 set-2 to Hack keyboard translator: tracks shift/caps and a stack of held keys,
// so kbd_out always shows the most recently pressed key that is still down.
module hack_kbd #(
  parameter int STACK_DEPTH = 4,
  parameter bit CAPS_ENABLE = 1'b1,
  parameter int OUT_W       = 16,
  localparam int CW         = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic [10:0]      ps2_key,
  input  logic             clear,
  output logic [OUT_W-1:0] kbd_out,
  output logic             key_valid,
  output logic             overflow,
  output logic [CW-1:0]    held_count
);

  localparam logic [8:0] KEY_LSHIFT = 9'h012;
  localparam logic [8:0] KEY_RSHIFT = 9'h059;
  localparam logic [8:0] KEY_CAPS   = 9'h058;

  // Letters follow shift^caps (up); everything else follows shift alone (sh).
  function automatic logic [7:0] xlate(input logic [8:0] key, input logic up, input logic sh);
    logic [7:0] lc, pl, su;
    lc = 8'd0;
    pl = 8'd0;
    su = 8'd0;
    if (!key[8]) begin
      case (key[7:0])
        8'h1C: lc = "a";  8'h32: lc = "b";  8'h21: lc = "c";  8'h23: lc = "d";
        8'h24: lc = "e";  8'h2B: lc = "f";  8'h34: lc = "g";  8'h33: lc = "h";
        8'h43: lc = "i";  8'h3B: lc = "j";  8'h42: lc = "k";  8'h4B: lc = "l";
        8'h3A: lc = "m";  8'h31: lc = "n";  8'h44: lc = "o";  8'h4D: lc = "p";
        8'h15: lc = "q";  8'h2D: lc = "r";  8'h1B: lc = "s";  8'h2C: lc = "t";
        8'h3C: lc = "u";  8'h2A: lc = "v";  8'h1D: lc = "w";  8'h22: lc = "x";
        8'h35: lc = "y";  8'h1A: lc = "z";
        default: lc = 8'd0;
      endcase
      case (key[7:0])
        8'h16: {pl, su} = "1!";  8'h1E: {pl, su} = "2@";  8'h26: {pl, su} = "3#";
        8'h25: {pl, su} = "4$";  8'h2E: {pl, su} = "5%";  8'h36: {pl, su} = "6^";
        8'h3D: {pl, su} = "7&";  8'h3E: {pl, su} = "8*";  8'h46: {pl, su} = "9(";
        8'h45: {pl, su} = "0)";  8'h0E: {pl, su} = "`~";  8'h4E: {pl, su} = "-_";
        8'h55: {pl, su} = "=+";  8'h54: {pl, su} = "[{";  8'h5B: {pl, su} = "]}";
        8'h5D: {pl, su} = {8'd92, 8'd124}; 8'h4C: {pl, su} = ";:";
        8'h52: {pl, su} = {8'd39, 8'd34};
        8'h41: {pl, su} = ",<";  8'h49: {pl, su} = ".>";  8'h4A: {pl, su} = "/?";
        // keypad without E0 prefix yields its printed character
        8'h70: {pl, su} = "00";  8'h69: {pl, su} = "11";  8'h72: {pl, su} = "22";
        8'h7A: {pl, su} = "33";  8'h6B: {pl, su} = "44";  8'h73: {pl, su} = "55";
        8'h74: {pl, su} = "66";  8'h6C: {pl, su} = "77";  8'h75: {pl, su} = "88";
        8'h7D: {pl, su} = "99";  8'h71: {pl, su} = "..";  8'h7C: {pl, su} = "**";
        8'h7B: {pl, su} = "--";  8'h79: {pl, su} = "++";  8'h29: {pl, su} = "  ";
        8'h5A: {pl, su} = {8'd128, 8'd128};  8'h66: {pl, su} = {8'd129, 8'd129};
        8'h76: {pl, su} = {8'd140, 8'd140};  8'h05: {pl, su} = {8'd141, 8'd141};
        8'h06: {pl, su} = {8'd142, 8'd142};  8'h04: {pl, su} = {8'd143, 8'd143};
        8'h0C: {pl, su} = {8'd144, 8'd144};  8'h03: {pl, su} = {8'd145, 8'd145};
        8'h0B: {pl, su} = {8'd146, 8'd146};  8'h83: {pl, su} = {8'd147, 8'd147};
        8'h0A: {pl, su} = {8'd148, 8'd148};  8'h01: {pl, su} = {8'd149, 8'd149};
        8'h09: {pl, su} = {8'd150, 8'd150};  8'h78: {pl, su} = {8'd151, 8'd151};
        8'h07: {pl, su} = {8'd152, 8'd152};
        default: {pl, su} = 16'd0;
      endcase
    end else begin
      case (key[7:0])
        8'h5A: pl = 8'd128;  8'h6B: pl = 8'd130;  8'h75: pl = 8'd131;  8'h74: pl = 8'd132;
        8'h72: pl = 8'd133;  8'h6C: pl = 8'd134;  8'h69: pl = 8'd135;  8'h7D: pl = 8'd136;
        8'h7A: pl = 8'd137;  8'h70: pl = 8'd138;  8'h71: pl = 8'd139;  8'h4A: pl = "/";
        default: pl = 8'd0;
      endcase
      su = pl;
    end
    if (lc != 8'd0) return up ? (lc - 8'd32) : lc;
    return sh ? su : pl;
  endfunction

  // Stage 1: decoded event
  logic       prev_tog_q, ev_vld_q, ev_make_q, clr_q;
  logic [8:0] ev_key_q;

  always_ff @(posedge clk_sys) begin
    prev_tog_q <= ps2_key[10];
    if (!reset_n) begin
      ev_vld_q  <= 1'b0;
      ev_make_q <= 1'b0;
      ev_key_q  <= '0;
      clr_q     <= 1'b0;
    end else begin
      ev_vld_q  <= (ps2_key[10] != prev_tog_q) && !clear;
      ev_make_q <= ps2_key[9];
      ev_key_q  <= ps2_key[8:0];
      clr_q     <= clear;
    end
  end

  // Stage 2: held-key stack (entry 0 = oldest, entry cnt_q-1 = top) and modifiers
  logic [8:0]    stk_q [STACK_DEPTH];
  logic [8:0]    stk_d [STACK_DEPTH];
  logic [CW-1:0] cnt_q, cnt_d, hit_idx;
  logic          lsh_q, lsh_d, rsh_q, rsh_d, caps_q, caps_d, ovf_q, ovf_d;
  logic          hit, mappable;

  always_comb begin
    stk_d    = stk_q;
    cnt_d    = cnt_q;
    lsh_d    = lsh_q;
    rsh_d    = rsh_q;
    caps_d   = caps_q;
    ovf_d    = ovf_q;
    hit      = 1'b0;
    hit_idx  = '0;
    mappable = xlate(ev_key_q, 1'b0, 1'b0) != 8'd0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (!hit && CW'(i) < cnt_q && stk_q[i] == ev_key_q) begin
        hit     = 1'b1;
        hit_idx = CW'(i);
      end
    end
    if (clr_q) begin
      cnt_d = '0;
      lsh_d = 1'b0;
      rsh_d = 1'b0;
      ovf_d = 1'b0;
    end else if (ev_vld_q) begin
      case (ev_key_q)
        KEY_LSHIFT: lsh_d = ev_make_q;
        KEY_RSHIFT: rsh_d = ev_make_q;
        KEY_CAPS:   if (ev_make_q && CAPS_ENABLE) caps_d = ~caps_q;
        default: begin
          if (ev_make_q) begin
            if (!hit && mappable) begin
              if (cnt_q < CW'(STACK_DEPTH)) begin
                for (int i = 0; i < STACK_DEPTH; i++)
                  if (CW'(i) == cnt_q) stk_d[i] = ev_key_q;
                cnt_d = cnt_q + CW'(1);
              end else begin
                for (int i = 0; i < STACK_DEPTH - 1; i++) stk_d[i] = stk_q[i+1];
                stk_d[STACK_DEPTH-1] = ev_key_q;
                ovf_d = 1'b1;
              end
            end
          end else if (hit) begin
            for (int i = 0; i < STACK_DEPTH - 1; i++)
              if (CW'(i) >= hit_idx) stk_d[i] = stk_q[i+1];
            cnt_d = cnt_q - CW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      for (int i = 0; i < STACK_DEPTH; i++) stk_q[i] <= '0;
      cnt_q  <= '0;
      lsh_q  <= 1'b0;
      rsh_q  <= 1'b0;
      caps_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      stk_q  <= stk_d;
      cnt_q  <= cnt_d;
      lsh_q  <= lsh_d;
      rsh_q  <= rsh_d;
      caps_q <= caps_d;
      ovf_q  <= ovf_d;
    end
  end

  // Stage 3: translate the top entry with the live modifier state
  logic [8:0] top_key;
  logic [7:0] xl;
  logic       shift;
  logic [OUT_W-1:0] kbd_q;
  logic       kv_q;

  assign shift = lsh_q | rsh_q;

  always_comb begin
    top_key = '0;
    for (int i = 0; i < STACK_DEPTH; i++)
      if (CW'(i + 1) == cnt_q) top_key = stk_q[i];
    xl = (cnt_q == '0) ? 8'd0 : xlate(top_key, shift ^ caps_q, shift);
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      kbd_q <= '0;
      kv_q  <= 1'b0;
    end else begin
      kbd_q <= OUT_W'(xl);
      kv_q  <= (xl != 8'd0);
    end
  end

  assign kbd_out    = kbd_q;
  assign key_valid  = kv_q;
  assign overflow   = ovf_q;
  assign held_count = cnt_q;

endmodule

// File: tb/tb_hack_kbd.sv
// Directed bench for hack_kbd: a queue-based model of the held keys is checked every
// cycle, and literal expectations at key points pin the model itself.
module tb_hack_kbd;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  // clock / reset
  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic [10:0]   ps2_key;
  logic          clear;
  logic [15:0]   kbd_out;
  logic          key_valid;
  logic          overflow;
  logic [CW-1:0] held_count;

  always #5 clk_sys = ~clk_sys;

  hack_kbd #(.STACK_DEPTH(D), .CAPS_ENABLE(1'b1), .OUT_W(16)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .clear(clear),
    .kbd_out(kbd_out), .key_valid(key_valid), .overflow(overflow), .held_count(held_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference translation tables
  localparam logic [7:0] LETTER_SC [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B,
    8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] SYM_SC [21] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
    8'h3E, 8'h46, 8'h45, 8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41,
    8'h49, 8'h4A};
  localparam logic [7:0] KP_SC [14] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74,
    8'h6C, 8'h75, 8'h7D, 8'h71, 8'h7C, 8'h7B, 8'h79};
  localparam logic [7:0] F_SC [12] = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83,
    8'h0A, 8'h01, 8'h09, 8'h78, 8'h07};
  localparam logic [7:0] NAV_SC [10] = '{8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C, 8'h69, 8'h7D,
    8'h7A, 8'h70, 8'h71};
  localparam logic [7:0] SYM_LO [21] = '{8'd49, 8'd50, 8'd51, 8'd52, 8'd53, 8'd54, 8'd55,
    8'd56, 8'd57, 8'd48, 8'd96, 8'd45, 8'd61, 8'd91, 8'd93, 8'd92, 8'd59, 8'd39, 8'd44,
    8'd46, 8'd47};
  localparam logic [7:0] SYM_HI [21] = '{8'd33, 8'd64, 8'd35, 8'd36, 8'd37, 8'd94, 8'd38,
    8'd42, 8'd40, 8'd41, 8'd126, 8'd95, 8'd43, 8'd123, 8'd125, 8'd124, 8'd58, 8'd34, 8'd60,
    8'd62, 8'd63};
  string kp_ch  = "0123456789.*-+";

  function automatic int unsigned m_xl(input logic [8:0] k, input bit sh, input bit cp);
    if (!k[8]) begin
      for (int i = 0; i < 26; i++) if (k[7:0] == LETTER_SC[i]) return (sh ^ cp) ? 65 + i : 97 + i;
      for (int i = 0; i < 21; i++) if (k[7:0] == SYM_SC[i]) return sh ? SYM_HI[i] : SYM_LO[i];
      for (int i = 0; i < 14; i++) if (k[7:0] == KP_SC[i]) return kp_ch[i];
      for (int i = 0; i < 12; i++) if (k[7:0] == F_SC[i]) return 141 + i;
      if (k[7:0] == 8'h29) return 32;
      if (k[7:0] == 8'h5A) return 128;
      if (k[7:0] == 8'h66) return 129;
      if (k[7:0] == 8'h76) return 140;
    end else begin
      for (int i = 0; i < 10; i++) if (k[7:0] == NAV_SC[i]) return 130 + i;
      if (k[7:0] == 8'h5A) return 128;
      if (k[7:0] == 8'h4A) return 47;
    end
    return 0;
  endfunction

  // model state: held keys oldest-first, modifiers, sticky overflow
  logic [8:0]  held[$];
  bit          m_lsh, m_rsh, m_caps, m_ovf, m_prev, started;
  int unsigned m_kbd_prev;
  logic [31:0] exp_cnt, exp_ovf, exp_kbd;

  function automatic int unsigned m_top();
    if (held.size() == 0) return 0;
    return m_xl(held[held.size()-1], m_lsh | m_rsh, m_caps);
  endfunction

  task automatic m_apply(input bit mk, input logic [8:0] k);
    bit found;
    if (k == 9'h012) m_lsh = mk;
    else if (k == 9'h059) m_rsh = mk;
    else if (k == 9'h058) begin
      if (mk) m_caps = !m_caps;
    end else if (mk) begin
      found = 1'b0;
      foreach (held[i]) if (held[i] == k) found = 1'b1;
      if (!found && m_xl(k, 1'b0, 1'b0) != 0) begin
        if (held.size() == D) begin
          void'(held.pop_front());
          m_ovf = 1'b1;
        end
        held.push_back(k);
      end
    end else begin
      for (int i = 0; i < held.size(); i++)
        if (held[i] == k) begin
          held.delete(i);
          break;
        end
    end
  endtask

  // scoreboard: update model at each edge, compare at the following falling edge
  initial begin
    bit ev;
    started = 1'b0;
    forever begin
      @(posedge clk_sys);
      if (!reset_n) begin
        held.delete();
        m_lsh = 0; m_rsh = 0; m_caps = 0; m_ovf = 0;
        m_prev = ps2_key[10];
        m_kbd_prev = 0;
        exp_cnt = 0; exp_ovf = 0; exp_kbd = 0;
        started = 1'b1;
      end else begin
        exp_cnt    = held.size();
        exp_ovf    = m_ovf;
        exp_kbd    = m_kbd_prev;
        m_kbd_prev = m_top();
        ev         = (ps2_key[10] != m_prev);
        m_prev     = ps2_key[10];
        if (clear) begin
          held.delete();
          m_lsh = 0; m_rsh = 0; m_ovf = 0;
        end else if (ev) m_apply(ps2_key[9], ps2_key[8:0]);
      end
      @(negedge clk_sys);
      if (started) begin
        check("model_held_count", held_count, exp_cnt);
        check("model_overflow", overflow, exp_ovf);
        check("model_kbd_out", kbd_out, exp_kbd);
        check("model_key_valid", key_valid, exp_kbd != 0);
      end
    end
  end

  // driver tasks (called at a falling edge)
  task automatic send(input bit mk, input bit ext, input logic [7:0] code, input bit clr = 1'b0);
    ps2_key = {~ps2_key[10], mk, ext, code};
    clear   = clr;
    @(negedge clk_sys);
    clear   = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic press(input logic [7:0] code, input bit ext = 1'b0);
    send(1'b1, ext, code);
    settle();
  endtask

  task automatic release_key(input logic [7:0] code, input bit ext = 1'b0);
    send(1'b0, ext, code);
    settle();
  endtask

  initial begin
    // reset with toggle high and a make of 'a' parked on the bus
    reset_n = 1'b0;
    clear   = 1'b0;
    ps2_key = 11'h61C;
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (4) @(negedge clk_sys);
    check("reset_kbd", kbd_out, 0);
    check("reset_held", held_count, 0);
    check("reset_valid", key_valid, 0);

    // shift over a single key
    press(8'h1C);   check("a_kbd", kbd_out, 97);  check("a_valid", key_valid, 1);
    press(8'h12);   check("lshift_a", kbd_out, 65);
    release_key(8'h12); check("unshift_a", kbd_out, 97);
    release_key(8'h1C); check("rel_a_kbd", kbd_out, 0); check("rel_a_valid", key_valid, 0);

    // stack reveal and typematic repeat
    press(8'h1C); press(8'h32); check("ab_kbd", kbd_out, 98);
    release_key(8'h32);         check("rel_b_kbd", kbd_out, 97);
    press(8'h1C);               check("repeat_held", held_count, 1);
    release_key(8'h1C);

    // overflow: five letters back to back
    send(1, 0, 8'h1C); send(1, 0, 8'h32); send(1, 0, 8'h21); send(1, 0, 8'h23); send(1, 0, 8'h24);
    settle();
    check("ovf_flag", overflow, 1); check("ovf_held", held_count, 4); check("ovf_kbd", kbd_out, 101);
    release_key(8'h24); check("ovf_rel_e", kbd_out, 100);
    release_key(8'h23); check("ovf_rel_d", kbd_out, 99);
    release_key(8'h21); check("ovf_rel_c", kbd_out, 98);
    release_key(8'h32); check("ovf_rel_b", kbd_out, 0); check("ovf_sticky", overflow, 1);

    // middle-of-stack release compacts
    send(1, 0, 8'h1C); send(1, 0, 8'h32); send(1, 0, 8'h21); settle();
    release_key(8'h32); check("mid_rel_kbd", kbd_out, 99); check("mid_rel_held", held_count, 2);
    release_key(8'h21); check("mid_rel_c", kbd_out, 97);
    release_key(8'h1C);

    // extended vs plain, shifted symbol, unmappable
    press(8'h6B, 1'b1); check("ext_left", kbd_out, 130); release_key(8'h6B, 1'b1);
    press(8'h6B);       check("kp4", kbd_out, 52);       release_key(8'h6B);
    press(8'h5A, 1'b1); check("ext_enter", kbd_out, 128); release_key(8'h5A, 1'b1);
    press(8'h59); press(8'h16); check("rshift_1", kbd_out, 33);
    release_key(8'h16); release_key(8'h59);
    press(8'h1C, 1'b1); check("ext_unmapped", held_count, 0);
    release_key(8'h1C, 1'b1);

    // caps, then clear racing a make
    send(1, 0, 8'h58); send(0, 0, 8'h58); settle();
    press(8'h12); press(8'h1C); check("caps_shift_a", kbd_out, 97);
    send(1, 0, 8'h32, 1'b1); settle();
    check("clear_held", held_count, 0); check("clear_kbd", kbd_out, 0); check("clear_ovf", overflow, 0);
    press(8'h1C); check("caps_kept_a", kbd_out, 65);
    release_key(8'h1C);
    send(1, 0, 8'h58); settle();
    press(8'h1C); check("caps_off_a", kbd_out, 97);
    release_key(8'h1C);

    repeat (3) @(negedge clk_sys);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
